// File: rtl/regb_fifo_packer.sv
// Pops WIDTH-bit words from a register FIFO and packs K of them into one K*WIDTH-bit valid/ready word.
// Define REGB_FIFO_PACKER_FLUSH_EN to add flush/out_count for emitting partially filled words.
module regb_fifo_packer #(
  parameter int WIDTH = 4,
  parameter int K     = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [WIDTH-1:0]      fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_shift_out,
`ifdef REGB_FIFO_PACKER_FLUSH_EN
  input  logic                  flush,
  output logic [$clog2(K):0]    out_count,
`endif
  output logic [K*WIDTH-1:0]    out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int IW = $clog2(K);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [K-1:0][WIDTH-1:0] lanes_q, lanes_d;
  logic                    pop;
  logic                    last;
  logic                    flush_go;

  // In HOLD a pop is only safe when the packed word leaves on the same edge.
  assign pop            = ~res & ~fifo_empty & ((state_q == FILL) | out_ready);
  assign fifo_shift_out = pop;
  assign out_valid      = (state_q == HOLD);
  assign out_data       = lanes_q;
  assign last           = (idx_q == LAST_IDX);

`ifdef REGB_FIFO_PACKER_FLUSH_EN
  logic [CW-1:0] cnt_q, cnt_d;

  assign flush_go  = flush & (state_q == FILL) & ((idx_q != '0) | pop);
  assign out_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_go)
      cnt_d = CW'(idx_q) + CW'(pop);
    else if ((state_q == FILL) && pop && last)
      cnt_d = CW'(K);
    else if ((state_q == HOLD) && out_ready)
      cnt_d = '0;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign flush_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    case (state_q)
      FILL: begin
        if (pop) begin
          lanes_d[idx_q] = fifo_rdata;
          idx_d          = idx_q + 1'b1;
          if (last) begin
            state_d = HOLD;
            idx_d   = '0;
          end
        end
        // A flush seals whatever has been written so far; unwritten lanes stay 0.
        if (flush_go) begin
          state_d = HOLD;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          lanes_d = '0;
          idx_d   = '0;
          if (pop) begin
            lanes_d[0] = fifo_rdata;
            idx_d      = IW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: doc/regb_fifo_packer.md
Name: regb_fifo_packer

Overview:
- Downstream consumer of the register-based FIFO: pops WIDTH-bit words through the FIFO's empty/shift_out interface.
- Packs K consecutive words into one K*WIDTH-bit output word.
- Presents each packed word on a valid/ready handshake to the next stage.
- Provides width up-conversion between the narrow FIFO stream and a wide sink; sustains one pop per cycle when the sink is ready.

Parameters:
- WIDTH, 4, bits per FIFO word; must match the FIFO's WIDTH.
- K, 4, words per packed output word; K >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- res  in  1  reset; asynchronous, active-high
- fifo_rdata  in  WIDTH  head word of the FIFO; valid while fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_shift_out  out  WIDTH=1  pop strobe to the FIFO; head is removed at the clock edge where it is 1
- out_data  out  K*WIDTH  packed word; lane j = bits [j*WIDTH +: WIDTH]
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  sink accepts out_data at the edge where out_valid & out_ready

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (res=1, async):
  - state=FILL, lane index idx=0, out_data=0, out_valid=0.
  - fifo_shift_out=0 combinationally while res=1.
  - Any partial word is discarded.
- Pop condition, combinational:
  - FILL: fifo_shift_out = ~fifo_empty.
  - HOLD: fifo_shift_out = ~fifo_empty & out_ready.
  - fifo_shift_out is never 1 while fifo_empty=1.
- Lane order: the first popped word goes to lane 0 (LSBs), the K-th to lane K-1.
- State FILL (out_valid=0):
  - Pop with idx<K-1: lane idx <= fifo_rdata; idx++.
  - Pop with idx=K-1: lane K-1 <= fifo_rdata; idx <= 0; go to HOLD.
  - No pop: hold all state.
- State HOLD (out_valid=1):
  - out_data is stable until the transfer.
  - out_ready=0: hold everything; no pop.
  - out_ready=1, no pop: go to FILL; out_data <= 0; idx=0.
  - out_ready=1 with a simultaneous pop: go to FILL; out_data <= {0, fifo_rdata} (lane 0 loaded, other lanes zeroed); idx <= 1.
- Latency: out_valid rises the cycle after the K-th pop.
- Throughput: with a continuously non-empty FIFO and out_ready=1, one packed word every K cycles with no bubbles.
- Lanes not yet written in FILL read 0; out_data is only meaningful while out_valid=1.
- Reset mid-word or mid-HOLD returns to the reset state immediately; no partial output is emitted.

Optional Feature:
- Macro: REGB_FIFO_PACKER_FLUSH_EN.
- With the macro defined:
  - Adds input flush (1 bit) and output out_count (clog2(K)+1 bits).
  - flush=1 in FILL with idx>0, or with a pop in the same cycle (the popped word is included first): go to HOLD with the unwritten lanes at 0.
  - out_count = number of valid lanes; equals K for normal words.
  - flush in FILL with idx=0 and no pop: ignored.
  - flush in HOLD: ignored.
  - out_count resets to 0.
- Without the macro: no flush or out_count ports; behaviour is exactly as above.

Test Plan (WIDTH=4, K=4):
- Reset then FIFO holding 1,2,3,4, out_ready=1 -> 4 pops on consecutive cycles; next cycle out_valid=1, out_data=16'h4321; one cycle later out_valid=0.
- FIFO empty throughout -> fifo_shift_out stays 0, out_valid stays 0, out_data=0.
- Words A,B,C,D,E,F,7,8 back-to-back, out_ready=1 -> out_data=16'hDCBA, then 16'h87FE exactly 4 cycles later; fifo_shift_out never drops while the FIFO is non-empty.
- out_ready=0 while HOLD with 16'h4321, FIFO non-empty -> out_valid stays 1, out_data unchanged, fifo_shift_out=0; raise out_ready -> transfer, and the pending head word loads lane 0 in the same edge.
- After 2 pops (5,6), assert res for 1 cycle -> out_data=0, out_valid=0; next pops 1,2,3,4 give 16'h4321 (5,6 discarded).
- FLUSH_EN: pops 9,A, then flush with FIFO empty -> out_valid=1, out_data=16'h00A9, out_count=2; flush in the same cycle as the 3rd pop of B -> 16'h0BA9, out_count=3.
